mu0_sequencer: RTL and testbench
================================

// Module: mu0_sequencer
// PURPOSE
//  Parametrised multi-cycle control sequencer for the MU0 datapath: an explicit FSM replacing the fetch/execute toggle.
//  Adds a memory-ready handshake with wait-state timeout, illegal-opcode trap, and a HALT state with run/resume.
//  Drives the existing datapath strobes (a_sel, b_sel, pc_ce, ir_ce, acc_ce, acc_oe, alufs, rnw, memrq) from IR opcode + ACC flags.
// PARAMETERS
//  OPCODE_W  4   IR opcode width (>=4); any opcode with bits [OPCODE_W-1:3] nonzero is illegal
//  ALUFS_W   3   ALU function select width (>=3); codes zero-extended
//  MAX_WAIT  15  max consecutive memrq&&!mem_rdy cycles before bus error; 0 disables timeout
//  WAIT_W    4   wait counter width; must hold MAX_WAIT
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst_n      in   1         asynchronous active-low reset
//  in_opcode  in   OPCODE_W  opcode field of IR (valid in EXEC)
//  acc_15     in   1         ACC sign bit
//  accz       in   1         ACC == 0
//  mem_rdy    in   1         memory completes current memrq access this cycle
//  run        in   1         resume from HALT (level, sampled in HALT only)
//  a_sel      out  1         address mux: 0=PC, 1=IR operand S
//  b_sel      out  1         ALU B mux: 0=PC, 1=memory data
//  pc_ce/ir_ce/acc_ce out 1  register clock enables
//  acc_oe     out  1         ACC drives memory data bus
//  alufs      out  ALUFS_W   1=A+B 2=A-B 3=B 4=B+1; 0 when idle
//  rnw        out  1         1=read 0=write
//  memrq      out  1         memory request
//  halted     out  1         FSM in HALT
//  illegal    out  1         sticky: illegal opcode trapped
//  bus_err    out  1         sticky: wait timeout trapped
// BEHAVIOUR
//  - States BOOT, FETCH, EXEC, HALT; state, wait counter, illegal, bus_err are flops; strobes decoded combinationally from state/opcode/flags/mem_rdy.
//  - Idle outputs (reset, BOOT, HALT): all ce/oe/sel=0, memrq=0, rnw=1, alufs=0. Async reset -> BOOT, illegal=bus_err=0, counter=0.
//  - BOOT: one cycle idle, then FETCH unconditionally.
//  - FETCH: a_sel=0 b_sel=0 memrq=1 rnw=1 alufs=4; pc_ce=ir_ce=mem_rdy; on mem_rdy -> EXEC, else hold.
//  - EXEC, by opcode (memrq=1, all ce gated by mem_rdy, exit on mem_rdy, else hold):
//     LDA(0)/ADD(2)/SUB(3): a_sel=1 b_sel=1 rnw=1 acc_ce, alufs=3/1/2 -> FETCH
//     STO(1): a_sel=1 acc_oe=1 rnw=0, no ce -> FETCH
//     JMP(4); JGE(5) taken iff acc_15=0; JNE(6) taken iff accz=0: a_sel=taken, b_sel=0, alufs=4, pc_ce=ir_ce -> EXEC (next instr already fetched)
//     STOP(7): idle outputs, no memrq -> HALT next cycle
//     illegal: idle outputs, illegal<=1 -> HALT next cycle
//  - Flags sampled combinationally in the mem_rdy cycle; ACC stable across EXEC.
//  - Wait counter: +1 each memrq&&!mem_rdy cycle, cleared on mem_rdy or state change; reaching MAX_WAIT (!=0) -> bus_err<=1, -> HALT, no ce pulsed.
//  - HALT: halted=1; run=1 -> FETCH next cycle, clears illegal and bus_err; run ignored elsewhere.
//  - mem_rdy ignored when memrq=0. Reset mid-access aborts immediately; no partial ce pulses after rst_n falls.
// STRUCTURE
//  - mu0_pkg: opcode localparams (OP_LDA..OP_STOP), ALUFS codes, state encoding.
//  - Sub-module mu0_wait_timer: WAIT_W counter, inputs req/rdy/clr, output timeout.
//  - Top: state register + decode, ~200 lines.
// TESTING
//  - Reset, release, mem_rdy=1: BOOT 1 cycle idle, FETCH pc_ce=ir_ce=1 alufs=4, then EXEC.
//  - LDA with mem_rdy low 3 cycles: memrq held, acc_ce=0 until 4th cycle acc_ce=1 alufs=3, then FETCH.
//  - JGE acc_15=1: a_sel=0 (not taken); acc_15=0: a_sel=1; both pc_ce=ir_ce=1, stay EXEC.
//  - JNE accz=1 not taken / accz=0 taken; STO: rnw=0 acc_oe=1 no ce.
//  - Opcode 8 (OPCODE_W=4): illegal=1, halted=1 next cycle; run=1 -> FETCH, illegal=0.
//  - MAX_WAIT=15, mem_rdy stuck 0 in FETCH: bus_err=1, HALT after 15 wait cycles; rst_n low mid-EXEC -> idle outputs at once.

Source files
------------

// File: rtl/mu0_sequencer_pkg.sv
// Shared definitions for the MU0 control sequencer: opcodes, ALU function codes,
// FSM state encoding and the datapath strobe bundle.
package mu0_sequencer_pkg;

    localparam logic [2:0] OP_LDA  = 3'd0;
    localparam logic [2:0] OP_STO  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_JMP  = 3'd4;
    localparam logic [2:0] OP_JGE  = 3'd5;
    localparam logic [2:0] OP_JNE  = 3'd6;
    localparam logic [2:0] OP_STOP = 3'd7;

    localparam logic [2:0] ALU_IDLE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_B    = 3'd3;
    localparam logic [2:0] ALU_INC  = 3'd4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef struct packed {
        logic a_sel;
        logic b_sel;
        logic pc_ce;
        logic ir_ce;
        logic acc_ce;
        logic acc_oe;
        logic rnw;
    } strobe_t;

    localparam strobe_t STRB_IDLE = '{a_sel: 1'b0, b_sel: 1'b0, pc_ce: 1'b0, ir_ce: 1'b0,
                                      acc_ce: 1'b0, acc_oe: 1'b0, rnw: 1'b1};

    // ALU function for the accumulator-loading instructions
    function automatic logic [2:0] alu_code(input logic [2:0] op);
        case (op)
            OP_LDA:  alu_code = ALU_B;
            OP_ADD:  alu_code = ALU_ADD;
            OP_SUB:  alu_code = ALU_SUB;
            default: alu_code = ALU_IDLE;
        endcase
    endfunction

    // Branch condition: JMP always, JGE on non-negative ACC, JNE on non-zero ACC
    function automatic logic jump_taken(input logic [2:0] op, input logic acc_15, input logic accz);
        case (op)
            OP_JMP:  jump_taken = 1'b1;
            OP_JGE:  jump_taken = !acc_15;
            OP_JNE:  jump_taken = !accz;
            default: jump_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mu0_sequencer_if.sv
// Control/status bundle between the MU0 sequencer (master) and the datapath/memory side (slave).
interface mu0_sequencer_if #(
    parameter int OPCODE_W = 4,
    parameter int ALUFS_W  = 3
);
    logic [OPCODE_W-1:0] in_opcode;
    logic                acc_15;
    logic                accz;
    logic                mem_rdy;
    logic                run;

    logic                a_sel;
    logic                b_sel;
    logic                pc_ce;
    logic                ir_ce;
    logic                acc_ce;
    logic                acc_oe;
    logic [ALUFS_W-1:0]  alufs;
    logic                rnw;
    logic                memrq;
    logic                halted;
    logic                illegal;
    logic                bus_err;

    modport master (
        input  in_opcode, acc_15, accz, mem_rdy, run,
        output a_sel, b_sel, pc_ce, ir_ce, acc_ce, acc_oe, alufs, rnw, memrq,
               halted, illegal, bus_err
    );

    modport slave (
        output in_opcode, acc_15, accz, mem_rdy, run,
        input  a_sel, b_sel, pc_ce, ir_ce, acc_ce, acc_oe, alufs, rnw, memrq,
               halted, illegal, bus_err
    );
endinterface

// File: rtl/mu0_sequencer_wait_timer.sv
// Counts consecutive stalled memory cycles and flags a timeout on the last one allowed.
module mu0_sequencer_wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic rdy,
    input  logic clr,
    output logic timeout
);
    // Timeout fires during the MAX_WAIT-th stalled cycle so the FSM leaves right after it
    localparam logic [WAIT_W-1:0] LIMIT_C = (MAX_WAIT == 0) ? {WAIT_W{1'b0}} : WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] count_r;
    logic              timeout_s;

    // Timeout decode; a zero limit disables the trap entirely
    always_comb begin
        if (MAX_WAIT != 0) begin
            timeout_s = req && !rdy && (count_r == LIMIT_C);
        end else begin
            timeout_s = 1'b0;
        end
    end

    assign timeout = timeout_s;

    // Stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WAIT_W{1'b0}};
        end else if (clr || !req || rdy || timeout_s) begin
            count_r <= {WAIT_W{1'b0}};
        end else begin
            count_r <= count_r + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: rtl/mu0_sequencer.sv
// MU0 control sequencer: BOOT/FETCH/EXEC/HALT FSM with memory-ready handshake,
// wait timeout, illegal-opcode trap and run/resume from HALT.
module mu0_sequencer
    import mu0_sequencer_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int ALUFS_W  = 3,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mu0_sequencer_if.master  bus
);
    state_e             state_r;
    state_e             state_nxt_s;
    state_e             done_state_s;
    state_e             idle_nxt_s;
    logic               illegal_r;
    logic               illegal_nxt_s;
    logic               bus_err_r;
    logic               bus_err_nxt_s;
    logic               req_s;
    logic               legal_s;
    logic               timeout_s;
    logic               clr_s;
    logic [2:0]         op_s;
    strobe_t            strb_s;
    logic [ALUFS_W-1:0] alufs_s;

    assign op_s    = bus.in_opcode[2:0];
    assign legal_s = ((bus.in_opcode >> 3) == {OPCODE_W{1'b0}});
    assign clr_s   = (state_r == ST_BOOT) || (state_r == ST_HALT);

    // Memory request depends on state and opcode only, keeping the timer out of any comb loop
    always_comb begin
        req_s = 1'b0;
        case (state_r)
            ST_FETCH: req_s = 1'b1;
            ST_EXEC:  req_s = legal_s && (op_s != OP_STOP);
            default:  req_s = 1'b0;
        endcase
    end

    mu0_sequencer_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_s),
        .rdy     (bus.mem_rdy),
        .clr     (clr_s),
        .timeout (timeout_s)
    );

    // Strobe decode and next-state selection
    always_comb begin
        strb_s        = STRB_IDLE;
        alufs_s       = {ALUFS_W{1'b0}};
        done_state_s  = state_r;
        idle_nxt_s    = state_r;
        illegal_nxt_s = illegal_r;
        bus_err_nxt_s = bus_err_r;

        case (state_r)
            ST_BOOT: begin
                idle_nxt_s = ST_FETCH;
            end
            ST_FETCH: begin
                alufs_s      = ALUFS_W'(ALU_INC);
                strb_s.pc_ce = bus.mem_rdy;
                strb_s.ir_ce = bus.mem_rdy;
                done_state_s = ST_EXEC;
            end
            ST_EXEC: begin
                if (!legal_s) begin
                    illegal_nxt_s = 1'b1;
                    idle_nxt_s    = ST_HALT;
                end else begin
                    case (op_s)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            strb_s.a_sel  = 1'b1;
                            strb_s.b_sel  = 1'b1;
                            strb_s.acc_ce = bus.mem_rdy;
                            alufs_s       = ALUFS_W'(alu_code(op_s));
                            done_state_s  = ST_FETCH;
                        end
                        OP_STO: begin
                            strb_s.a_sel  = 1'b1;
                            strb_s.acc_oe = 1'b1;
                            strb_s.rnw    = 1'b0;
                            done_state_s  = ST_FETCH;
                        end
                        OP_JMP, OP_JGE, OP_JNE: begin
                            // The branch cycle fetches the next instruction, so EXEC follows EXEC
                            strb_s.a_sel = jump_taken(op_s, bus.acc_15, bus.accz);
                            strb_s.pc_ce = bus.mem_rdy;
                            strb_s.ir_ce = bus.mem_rdy;
                            alufs_s      = ALUFS_W'(ALU_INC);
                            done_state_s = ST_EXEC;
                        end
                        OP_STOP: begin
                            idle_nxt_s = ST_HALT;
                        end
                        default: begin
                            idle_nxt_s = ST_HALT;
                        end
                    endcase
                end
            end
            ST_HALT: begin
                if (bus.run) begin
                    idle_nxt_s    = ST_FETCH;
                    illegal_nxt_s = 1'b0;
                    bus_err_nxt_s = 1'b0;
                end else begin
                    idle_nxt_s    = ST_HALT;
                end
            end
            default: begin
                idle_nxt_s = ST_BOOT;
            end
        endcase

        // Timeout implies !mem_rdy, so no enable has been pulsed in the trapping cycle
        if (!req_s) begin
            state_nxt_s = idle_nxt_s;
        end else if (timeout_s) begin
            state_nxt_s   = ST_HALT;
            bus_err_nxt_s = 1'b1;
        end else if (bus.mem_rdy) begin
            state_nxt_s = done_state_s;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and sticky trap flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_BOOT;
            illegal_r <= 1'b0;
            bus_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            illegal_r <= illegal_nxt_s;
            bus_err_r <= bus_err_nxt_s;
        end
    end

    assign bus.a_sel   = strb_s.a_sel;
    assign bus.b_sel   = strb_s.b_sel;
    assign bus.pc_ce   = strb_s.pc_ce;
    assign bus.ir_ce   = strb_s.ir_ce;
    assign bus.acc_ce  = strb_s.acc_ce;
    assign bus.acc_oe  = strb_s.acc_oe;
    assign bus.rnw     = strb_s.rnw;
    assign bus.alufs   = alufs_s;
    assign bus.memrq   = req_s;
    assign bus.halted  = (state_r == ST_HALT);
    assign bus.illegal = illegal_r;
    assign bus.bus_err = bus_err_r;
endmodule

// File: tb/tb_mu0_sequencer.sv
// Self-checking bench for mu0_sequencer: decode vector table plus wait, trap, timeout and reset sequences.
module tb_mu0_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mu0_sequencer_if #(.OPCODE_W(4), .ALUFS_W(3)) bus ();

    mu0_sequencer #(
        .OPCODE_W (4),
        .ALUFS_W  (3),
        .MAX_WAIT (15),
        .WAIT_W   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic        a15;
        logic        az;
        logic        rdy;
        logic [13:0] exp;
        logic [13:0] exp_after;
    } vec_t;

    vec_t        vecs [14];
    logic [13:0] sb_q [$];
    int          n_pass  = 0;
    int          n_total = 0;

    logic [13:0] idle_c, fetch_ok_c, fetch_wait_c, lda_ok_c, lda_wait_c;
    logic [13:0] halt_c, halt_ill_c, halt_bus_c;

    // Expected-output packing: a_sel b_sel pc_ce ir_ce acc_ce acc_oe alufs rnw memrq halted illegal bus_err
    function automatic logic [13:0] mk(input logic a, input logic b, input logic pc, input logic ir,
                                       input logic acc, input logic oe, input logic [2:0] fs,
                                       input logic rnw, input logic rq, input logic h,
                                       input logic il, input logic be);
        mk = {a, b, pc, ir, acc, oe, fs, rnw, rq, h, il, be};
    endfunction

    function automatic logic [13:0] actual();
        actual = {bus.a_sel, bus.b_sel, bus.pc_ce, bus.ir_ce, bus.acc_ce, bus.acc_oe, bus.alufs,
                  bus.rnw, bus.memrq, bus.halted, bus.illegal, bus.bus_err};
    endfunction

    task automatic set_in(input logic [3:0] op, input logic a15, input logic az,
                          input logic rdy, input logic run);
        bus.in_opcode = op;
        bus.acc_15    = a15;
        bus.accz      = az;
        bus.mem_rdy   = rdy;
        bus.run       = run;
    endtask

    task automatic drive(input logic [3:0] op, input logic a15, input logic az,
                         input logic rdy, input logic run, input logic [13:0] exp);
        set_in(op, a15, az, rdy, run);
        sb_q.push_back(exp);
    endtask

    task automatic check(input string name, input bit at_edge);
        logic [13:0] exp;
        logic [13:0] act;
        if (at_edge) @(negedge clk);
        act = actual();
        n_total++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s: no expected value queued, actual=%b", name, act);
        end else begin
            exp = sb_q.pop_front();
            if (act !== exp) $display("FAIL %s: actual=%b required=%b", name, act, exp);
            else n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, BOOT, FETCH with mem_rdy=1: leaves the FSM in EXEC
    task automatic goto_exec();
        rst_n = 1'b0;
        set_in(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        idle_c       = mk(0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0);
        fetch_ok_c   = mk(0, 0, 1, 1, 0, 0, 3'd4, 1, 1, 0, 0, 0);
        fetch_wait_c = mk(0, 0, 0, 0, 0, 0, 3'd4, 1, 1, 0, 0, 0);
        lda_ok_c     = mk(1, 1, 0, 0, 1, 0, 3'd3, 1, 1, 0, 0, 0);
        lda_wait_c   = mk(1, 1, 0, 0, 0, 0, 3'd3, 1, 1, 0, 0, 0);
        halt_c       = mk(0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 1, 0, 0);
        halt_ill_c   = mk(0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 1, 1, 0);
        halt_bus_c   = mk(0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 1, 0, 1);

        vecs[0]  = '{4'd0,  1'b0, 1'b0, 1'b1, lda_ok_c, fetch_ok_c};
        vecs[1]  = '{4'd2,  1'b0, 1'b0, 1'b1, mk(1, 1, 0, 0, 1, 0, 3'd1, 1, 1, 0, 0, 0), fetch_ok_c};
        vecs[2]  = '{4'd3,  1'b0, 1'b0, 1'b1, mk(1, 1, 0, 0, 1, 0, 3'd2, 1, 1, 0, 0, 0), fetch_ok_c};
        vecs[3]  = '{4'd1,  1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 0, 1, 3'd0, 0, 1, 0, 0, 0), fetch_ok_c};
        vecs[4]  = '{4'd4,  1'b1, 1'b1, 1'b1, mk(1, 0, 1, 1, 0, 0, 3'd4, 1, 1, 0, 0, 0),
                     mk(1, 0, 1, 1, 0, 0, 3'd4, 1, 1, 0, 0, 0)};
        vecs[5]  = '{4'd5,  1'b1, 1'b0, 1'b1, fetch_ok_c, fetch_ok_c};
        vecs[6]  = '{4'd5,  1'b0, 1'b0, 1'b1, mk(1, 0, 1, 1, 0, 0, 3'd4, 1, 1, 0, 0, 0),
                     mk(1, 0, 1, 1, 0, 0, 3'd4, 1, 1, 0, 0, 0)};
        vecs[7]  = '{4'd6,  1'b0, 1'b1, 1'b1, fetch_ok_c, fetch_ok_c};
        vecs[8]  = '{4'd6,  1'b0, 1'b0, 1'b1, mk(1, 0, 1, 1, 0, 0, 3'd4, 1, 1, 0, 0, 0),
                     mk(1, 0, 1, 1, 0, 0, 3'd4, 1, 1, 0, 0, 0)};
        vecs[9]  = '{4'd7,  1'b0, 1'b0, 1'b1, idle_c, halt_c};
        vecs[10] = '{4'd8,  1'b0, 1'b0, 1'b1, idle_c, halt_ill_c};
        vecs[11] = '{4'd15, 1'b0, 1'b0, 1'b1, idle_c, halt_ill_c};
        vecs[12] = '{4'd0,  1'b0, 1'b0, 1'b0, lda_wait_c, lda_wait_c};
        vecs[13] = '{4'd5,  1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 3'd4, 1, 1, 0, 0, 0),
                     mk(1, 0, 0, 0, 0, 0, 3'd4, 1, 1, 0, 0, 0)};

        // Reset state, BOOT idle, FETCH, first EXEC
        rst_n = 1'b0;
        drive(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, idle_c);
        check("reset_idle", 1'b1);
        tick();
        rst_n = 1'b1;
        drive(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, idle_c);
        check("boot_idle", 1'b1);
        tick();
        drive(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, fetch_ok_c);
        check("fetch_rdy", 1'b1);
        tick();
        drive(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, lda_ok_c);
        check("first_exec", 1'b1);

        // EXEC decode table: strobes in the cycle, then the following state's outputs
        for (int i = 0; i < 14; i++) begin
            goto_exec();
            drive(vecs[i].op, vecs[i].a15, vecs[i].az, vecs[i].rdy, 1'b0, vecs[i].exp);
            check($sformatf("vec%0d_exec", i), 1'b1);
            tick();
            sb_q.push_back(vecs[i].exp_after);
            check($sformatf("vec%0d_next", i), 1'b1);
        end

        // LDA stalled three cycles, completes on the fourth
        goto_exec();
        for (int k = 0; k < 3; k++) begin
            drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, lda_wait_c);
            check($sformatf("lda_wait%0d", k), 1'b1);
            tick();
        end
        drive(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, lda_ok_c);
        check("lda_done", 1'b1);
        tick();
        drive(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, fetch_ok_c);
        check("lda_to_fetch", 1'b1);

        // Illegal opcode trap and resume
        goto_exec();
        drive(4'd8, 1'b0, 1'b0, 1'b1, 1'b0, idle_c);
        check("ill_exec", 1'b1);
        tick();
        drive(4'd8, 1'b0, 1'b0, 1'b1, 1'b1, halt_ill_c);
        check("ill_halt_run", 1'b1);
        tick();
        drive(4'd8, 1'b0, 1'b0, 1'b1, 1'b0, fetch_ok_c);
        check("ill_resume", 1'b1);

        // mem_rdy stuck low in FETCH: 15 wait cycles, then bus error HALT
        rst_n = 1'b0;
        set_in(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 15; k++) begin
            drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, fetch_wait_c);
            check($sformatf("fetch_wait%0d", k), 1'b1);
            tick();
        end
        drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, halt_bus_c);
        check("timeout_halt", 1'b1);
        tick();
        drive(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, fetch_ok_c);
        check("timeout_resume", 1'b1);

        // Reset asserted mid-EXEC forces idle outputs without waiting for a clock
        goto_exec();
        drive(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, lda_ok_c);
        check("pre_reset_exec", 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.push_back(idle_c);
        check("reset_mid_exec", 1'b0);
        tick();
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
